median_win_gen: RTL and testbench

Streaming 3x3 window generator that produces the neighbourhood stream consumed by the median filter datapath. It accepts a raster-order pixel stream over a valid/ready handshake and buffers two image lines. For every interior pixel it emits one 9-pixel window over a second valid/ready handshake. It sits between the image input interface and the median_3-based filter tree.

---
 rtl/median_pkg.sv | 17 +
 rtl/median_line_buf.sv | 25 ++
 rtl/median_win_gen.sv | 141 ++++++++++++++
 tb/tb_median_win_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median window generator.
package median_pkg;

   localparam int unsigned DEF_DW = 8;
   localparam int unsigned WIN_N  = 9;

   typedef enum logic {
      FILL   = 1'b0,
      STREAM = 1'b1
   } phase_t;

   // Flat window element index for row offset dr, column offset dc.
   function automatic int unsigned win_idx(input int unsigned dr, input int unsigned dc);
      return 3 * dr + dc;
   endfunction

endpackage

// File: rtl/median_line_buf.sv
// One image line of delay: a DEPTH-deep shift register advanced by shift.
module median_line_buf #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DW    = 8
) (
   input  logic          clk,
   input  logic          shift,
   input  logic [DW-1:0] pix,
   output logic [DW-1:0] dly
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (shift) begin
         mem[0] <= pix;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign dly = mem[DEPTH-1];

endmodule

// File: rtl/median_win_gen.sv
// Streaming 3x3 window generator with two line buffers and a registered output stage.
// Optional MEDIAN_WIN_COORD_EN adds window-centre coordinate outputs o_row/o_col.
module median_win_gen
   import median_pkg::*;
#(
   parameter int unsigned IMG_W = 8,
   parameter int unsigned IMG_H = 8,
   parameter int unsigned DW    = DEF_DW
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_in_valid,
   input  logic [DW-1:0]         i_in_data,
   output logic                  o_in_ready,
   output logic                  o_out_valid,
   output logic [WIN_N*DW-1:0]   o_win,
   input  logic                  i_out_ready
`ifdef MEDIAN_WIN_COORD_EN
   ,
   output logic [$clog2(IMG_H)-1:0] o_row,
   output logic [$clog2(IMG_W)-1:0] o_col
`endif
);

   localparam int unsigned RW = $clog2(IMG_H);
   localparam int unsigned CW = $clog2(IMG_W);

   logic [RW-1:0] row;
   logic [CW-1:0] col;
   phase_t        phase;
   phase_t        phase_nxt;
   logic          accept;
   logic          produce_c;
   logic          row_end;
   logic          frame_end;
   logic [DW-1:0] lb1_dly;
   logic [DW-1:0] lb2_dly;
   logic [DW-1:0] col_in [3];
   // Per window row: [0] holds column C-2, [1] holds column C-1 before the shift.
   logic [DW-1:0] win_sr [3][2];

   assign o_in_ready = !o_out_valid || i_out_ready;
   assign accept     = i_in_valid && o_in_ready;
   assign row_end    = (col == CW'(IMG_W - 1));
   assign frame_end  = row_end && (row == RW'(IMG_H - 1));

   median_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
      .clk   (i_clk),
      .shift (accept),
      .pix   (i_in_data),
      .dly   (lb1_dly)
   );

   median_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb2 (
      .clk   (i_clk),
      .shift (accept),
      .pix   (lb1_dly),
      .dly   (lb2_dly)
   );

   assign col_in[0] = lb2_dly;
   assign col_in[1] = lb1_dly;
   assign col_in[2] = i_in_data;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         phase <= FILL;
      end else begin
         phase <= phase_nxt;
      end
   end

   always_comb begin
      phase_nxt = phase;
      case (phase)
         FILL:    if (accept && row == RW'(2) && col == '0) phase_nxt = STREAM;
         STREAM:  if (accept && frame_end) phase_nxt = FILL;
         default: phase_nxt = FILL;
      endcase
   end

   always_comb begin
      produce_c = 1'b0;
      if (phase == STREAM && accept && col >= CW'(2)) produce_c = 1'b1;
   end

   // Raster position of the next pixel to be accepted; no gap between frames.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         row <= '0;
         col <= '0;
      end else if (accept) begin
         if (row_end) begin
            col <= '0;
            row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         for (int unsigned dr = 0; dr < 3; dr++) begin
            win_sr[dr][0] <= win_sr[dr][1];
            win_sr[dr][1] <= col_in[dr];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_out_valid <= 1'b0;
         o_win       <= '0;
      end else if (accept) begin
         o_out_valid <= produce_c;
         if (produce_c) begin
            for (int unsigned dr = 0; dr < 3; dr++) begin
               o_win[DW*win_idx(dr, 0) +: DW] <= win_sr[dr][0];
               o_win[DW*win_idx(dr, 1) +: DW] <= win_sr[dr][1];
               o_win[DW*win_idx(dr, 2) +: DW] <= col_in[dr];
            end
         end
      end else if (i_out_ready) begin
         o_out_valid <= 1'b0;
      end
   end

`ifdef MEDIAN_WIN_COORD_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_row <= '0;
         o_col <= '0;
      end else if (produce_c) begin
         o_row <= row - RW'(1);
         o_col <= col - CW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_median_win_gen.sv
// Self-checking bench for median_win_gen: frame-array model plus pinned literal expectations.
module tb_median_win_gen;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int D  = 8;
   localparam int WB = 9 * D;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [D-1:0]  in_data;
   logic          in_ready;
   logic          out_valid;
   logic [WB-1:0] win;
   logic          out_ready = 1'b1;
`ifdef MEDIAN_WIN_COORD_EN
   logic [$clog2(H)-1:0] o_row;
   logic [$clog2(W)-1:0] o_col;
`endif

   always #5 clk = ~clk;

   median_win_gen #(.IMG_W(W), .IMG_H(H), .DW(D)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .i_in_data   (in_data),
      .o_in_ready  (in_ready),
      .o_out_valid (out_valid),
      .o_win       (win),
      .i_out_ready (out_ready)
`ifdef MEDIAN_WIN_COORD_EN
      ,
      .o_row       (o_row),
      .o_col       (o_col)
`endif
   );

   typedef struct {
      logic [WB-1:0] w;
      int            r;
      int            c;
   } exp_t;

   exp_t          q[$];
   logic [WB-1:0] got[$];
   logic [WB-1:0] ref_win[$];
   int            got_r[$];
   int            got_c[$];
   logic [D-1:0]  img [H][W];
   int            mr = 0;
   int            mc = 0;
   int            checks = 0;
   int            errors = 0;
   int            acc_cnt = 0;
   int            first_acc = -1;
   int            hold_cnt = 0;
   bit            rst_seen = 0;
   bit            hold_prev = 0;
   logic [WB-1:0] prev_win;
   bit            stall_en = 0;
   bit            gap_en = 0;

   task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: keep the whole frame in an array and cut windows from it.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         mr = 0;
         mc = 0;
         rst_seen = 1;
         hold_prev = 0;
      end else begin
         if (rst_seen) chk("rst_drop_valid", WB'(out_valid), WB'(0));
         rst_seen = 0;
         chk("valid_vs_model", WB'(out_valid), WB'(q.size() != 0));
         chk("in_ready", WB'(in_ready), WB'(!out_valid || out_ready));
         if (out_valid && hold_prev) chk("stall_hold", win, prev_win);
         if (out_valid && first_acc < 0) first_acc = acc_cnt;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_window", WB'(1), WB'(0));
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("window", win, e.w);
`ifdef MEDIAN_WIN_COORD_EN
               chk("coord_row", WB'(o_row), WB'(e.r - 1));
               chk("coord_col", WB'(o_col), WB'(e.c - 1));
               got_r.push_back(int'(o_row));
               got_c.push_back(int'(o_col));
`endif
            end
            got.push_back(win);
         end
         hold_prev = out_valid && !out_ready;
         if (hold_prev) hold_cnt++;
         prev_win = win;
         if (in_valid && in_ready) begin
            acc_cnt++;
            img[mr][mc] = in_data;
            if (mr >= 2 && mc >= 2) begin
               exp_t e;
               for (int dr = 0; dr < 3; dr++)
                  for (int dc = 0; dc < 3; dc++)
                     e.w[D*(3*dr+dc) +: D] = img[mr-2+dr][mc-2+dc];
               e.r = mr;
               e.c = mc;
               q.push_back(e);
            end
            mc++;
            if (mc == W) begin
               mc = 0;
               mr = (mr == H - 1) ? 0 : mr + 1;
            end
         end
      end
   end

   // Downstream ready: constant 1, or the 1,0,0,1 pattern when stalling.
   initial begin
      int k;
      logic pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      k = 0;
      forever begin
         @(posedge clk);
         #1;
         if (stall_en) begin
            out_ready = pat[k % 4];
            k++;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   task automatic send(input logic [D-1:0] d);
      int  n;
      bit  acc;
      n = 0;
      acc = 0;
      if (gap_en && $urandom_range(1) == 1) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
         if (n > 100) begin
            $display("FAIL send_timeout actual=stuck required=accept");
            $fatal(1);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic frame();
      for (int i = 0; i < W * H; i++) send(D'(i));
   endtask

   task automatic drain();
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic cmp_ref(input string name);
      chk({name, "_count"}, WB'(got.size()), WB'(36));
      for (int i = 0; i < 36 && i < got.size(); i++) chk(name, got[i], ref_win[i]);
   endtask

   initial begin
      logic [WB-1:0] first_lit;
      logic [D-1:0]  last_e8;
      first_lit = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_valid", WB'(out_valid), WB'(0));
      chk("reset_win", win, WB'(0));
      chk("reset_in_ready", WB'(in_ready), WB'(1));
      @(posedge clk);
      #1;

      // Two back-to-back ramp frames, ready held high.
      frame();
      frame();
      drain();
      chk("first_valid_after_pixel18", WB'(first_acc), WB'(19));
      chk("frame_pair_count", WB'(got.size()), WB'(72));
      if (got.size() == 72) begin
         chk("first_window_literal", got[0], first_lit);
         last_e8 = got[35][8*D +: D];
         chk("last_window_e8", WB'(last_e8), WB'(63));
         chk("second_frame_first", got[36], got[0]);
`ifdef MEDIAN_WIN_COORD_EN
         chk("first_row", WB'(got_r[0]), WB'(1));
         chk("first_col", WB'(got_c[0]), WB'(1));
         chk("last_row", WB'(got_r[35]), WB'(6));
         chk("last_col", WB'(got_c[35]), WB'(6));
`endif
      end
      for (int i = 0; i < 36 && i < got.size(); i++) ref_win.push_back(got[i]);
      got.delete();

      // Downstream stalls.
      stall_en = 1;
      frame();
      stall_en = 0;
      drain();
      cmp_ref("stall_seq");
      chk("stall_happened", WB'(hold_cnt > 0), WB'(1));
      got.delete();

      // Input gaps.
      gap_en = 1;
      frame();
      gap_en = 0;
      drain();
      cmp_ref("gap_seq");
      got.delete();

      // Reset mid-frame after 20 pixels, then a fresh frame.
      for (int i = 0; i < 20; i++) send(D'(i));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      got.delete();
      frame();
      drain();
      cmp_ref("post_reset_seq");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule
